// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
// Holds the FSM state encoding, the parity-mode constants and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  // acc is the XOR of all data bits; odd parity sends its inverse.
  function automatic logic parity_bit(input logic acc, input logic [1:0] mode);
    return (mode == PAR_ODD) ? ~acc : acc;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts CLKS_PER_BIT cycles and flags the last cycle of each period.
// Held at zero while clear_i is high so the first period after a clear is full length.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic bit_end_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || (cnt_q == CNT_MAX)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end_o = !clear_i && (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_fifo_tx.sv
// UART transmitter that pops one word at a time from a FIFO and serialises it
// as start, DATA_BITS data (LSB first), optional parity and STOP_BITS stop bits.
module uart_fifo_tx
  import uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         DATA_WIDTH   = 8,
  parameter int         DATA_BITS    = 8,
  parameter logic [1:0] PARITY       = PAR_NONE,
  parameter int         STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam logic [3:0] LAST_DATA_IDX = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP_IDX = 4'(STOP_BITS - 1);

  tx_state_e            state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [3:0]           bit_idx_q;
  logic                 par_q;
  logic                 tx_q;

  logic baud_clear;
  logic bit_end;
  logic pop_req;
  logic last_data;
  logic last_stop;
  logic unused_fifo_bits;

  // The timer only runs once a frame is on the line; IDLE and FETCH hold it at zero.
  assign baud_clear = (state_q == ST_IDLE) || (state_q == ST_FETCH);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (baud_clear),
    .bit_end_o(bit_end)
  );

  assign pop_req   = (state_q == ST_IDLE) && enable && !fifo_empty && !rst;
  assign last_data = (bit_idx_q == LAST_DATA_IDX);
  assign last_stop = (bit_idx_q == LAST_STOP_IDX);

  // Upper FIFO bits beyond DATA_BITS are deliberately never transmitted.
  assign unused_fifo_bits = ^fifo_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop_req) begin
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          shift_q   <= fifo_data[DATA_BITS-1:0];
          bit_idx_q <= '0;
          par_q     <= 1'b0;
          tx_q      <= 1'b0;
          state_q   <= ST_START;
        end
        ST_START: begin
          if (bit_end) begin
            tx_q    <= shift_q[0];
            state_q <= ST_DATA;
          end
        end
        // tx always carries shift_q[0]; each bit end shifts and folds it into parity.
        ST_DATA: begin
          if (bit_end) begin
            par_q   <= par_q ^ shift_q[0];
            shift_q <= shift_q >> 1;
            if (last_data) begin
              bit_idx_q <= '0;
              if (PARITY != PAR_NONE) begin
                tx_q    <= parity_bit(par_q ^ shift_q[0], PARITY);
                state_q <= ST_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= ST_STOP;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 4'd1;
              tx_q      <= shift_q[1];
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            tx_q    <= 1'b1;
            state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (last_stop) begin
              bit_idx_q <= '0;
              state_q   <= ST_IDLE;
            end else begin
              bit_idx_q <= bit_idx_q + 4'd1;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign fifo_read_en = pop_req;
  assign tx           = tx_q;
  assign busy         = (state_q != ST_IDLE);
  assign tx_done      = (state_q == ST_STOP) && bit_end && last_stop && !rst;

endmodule

// File: doc/uart_fifo_tx.md
UART_FIFO_TX -- requirements
Module: uart_fifo_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, 868, clock cycles per UART bit period (>=2).
REQ-002 Parameter DATA_BITS, 8, frame data bits, 5..8, at most DATA_WIDTH.
REQ-003 Parameter PARITY, PAR_NONE, parity mode: PAR_NONE / PAR_EVEN / PAR_ODD.
REQ-004 Parameter STOP_BITS, 1, number of stop bits, 1 or 2.
REQ-005 Port clk  input  1  single clock; all logic on posedge clk.
REQ-006 Port rst  input  1  reset, synchronous, active-high.
REQ-007 Port enable  input  1  permits starting a new frame.
REQ-008 Port fifo_empty  input  1  source FIFO has no data.
REQ-009 Port fifo_data  input  DATA_WIDTH  FIFO read data, valid the cycle after fifo_read_en.
REQ-010 Port fifo_read_en  output  1  one-cycle FIFO pop request.
REQ-011 Port tx  output  1  serial line, idle high.
REQ-012 Port busy  output  1  high in every state except IDLE.
REQ-013 Port tx_done  output  1  one-cycle pulse at end of final stop bit.

Function
REQ-014 The FSM SHALL have states IDLE, FETCH, START, DATA, PARITY, STOP.
REQ-015 IDLE with fifo_empty=0 and enable=1 SHALL assert fifo_read_en for exactly that cycle and enter FETCH; otherwise remain in IDLE.
REQ-016 FETCH SHALL latch fifo_data[DATA_BITS-1:0] into the shift register, ignore the upper bits, clear the bit-period counter and enter START; fifo_read_en=0.
REQ-017 Each of START, DATA-bit, PARITY and STOP-bit SHALL drive tx for exactly CLKS_PER_BIT cycles.
REQ-018 START SHALL drive tx=0.
REQ-019 DATA SHALL send DATA_BITS bits LSB first and count them with a bit index that wraps to 0 on exit.
REQ-020 PARITY SHALL be entered only when PARITY!=PAR_NONE: even -> XOR of the data bits, odd -> its inverse.
REQ-021 STOP SHALL drive tx=1 for STOP_BITS bit periods, pulse tx_done in the last cycle, then return to IDLE.
REQ-022 The minimum inter-frame gap SHALL be 2 cycles of tx=1: one IDLE cycle plus one FETCH cycle.
REQ-023 An enable deassertion mid-frame SHALL NOT abort the frame; it only blocks the next pop.
REQ-024 fifo_empty and fifo_data SHALL be ignored outside IDLE and FETCH respectively.
REQ-025 fifo_read_en SHALL never assert while fifo_empty=1 or while busy=1.
REQ-026 tx SHALL be registered, with no combinational path from any input to tx.

Reset
REQ-027 On rst=1 at a clock edge: state=IDLE, tx=1, busy=0, fifo_read_en=0, tx_done=0, counters and shift register cleared.
REQ-028 rst asserted mid-frame SHALL abandon the frame, with tx=1 from the next edge and no FIFO pop.
REQ-029 rst SHALL take priority over any simultaneous FIFO or enable event.

Structure
REQ-030 A shared package uart_pkg SHALL hold the state enum type and the PAR_NONE/PAR_EVEN/PAR_ODD constants.
REQ-031 A sub-module uart_baud_gen SHALL hold the CLKS_PER_BIT counter, with a clear input and a one-cycle bit_end output.
REQ-032 The top SHALL contain the FSM, shift register, bit index and parity accumulator; target 120-400 RTL lines.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-033 Idle: fifo_empty=1, enable=1 for 20 cycles -> fifo_read_en=0, tx=1, busy=0, tx_done=0 throughout.
REQ-034 8N1, fifo_data=0xAA -> fifo_read_en pulse 1 cycle, then tx bit sequence 0,0,1,0,1,0,1,0,1,1 at 4 cycles each, tx_done in cycle 40 after FETCH, busy=0 after.
REQ-035 8E1, 0x07 -> parity bit 1; 8O1, 0x07 -> parity bit 0; 11 bit periods each.
REQ-036 DATA_BITS=7, STOP_BITS=2, fifo_data=0xFF -> start, 7 ones, 2 stop bits; bit 7 not transmitted; frame is 10 periods.
REQ-037 Back-to-back: FIFO holds 0x55 then 0x0F -> exactly 2 fifo_read_en pulses, 2 tx=1 gap cycles between frames, 2 tx_done pulses.
REQ-038 Reset mid-frame: rst during data bit 3 of 0xAA -> tx=1, busy=0 next cycle, no fifo_read_en; a later frame transmits correctly.
